core_dispatch_queue: RTL and testbench
======================================

# core_dispatch_queue

Per-core instruction buffer that sits directly downstream of the instruction arbiter, one instance per core. It absorbs the 32-bit instruction words the arbiter steers toward its core and presents them to the core in order through a valid/ready handshake. It also caps the number of issued-but-unretired instructions per core. Back-pressure and an almost-full flag are fed back to the arbiter.

## Interface
- DEPTH, 32, number of entries; power of two, at least 4.
- ALMOST_FULL_TH, DEPTH-4, occupancy at or above which almost_full asserts.
- MAX_INFLIGHT, 4, maximum number of issued, not yet retired instructions; at least 1.
- clk  input  1  single clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- in_instr  input  32  instruction word from the arbiter.
- in_valid  input  1  in_instr is valid this cycle.
- in_ready  output  1  queue accepts a push this cycle.
- out_instr  output  32  instruction at the head of the queue.
- out_valid  output  1  out_instr may be issued this cycle.
- out_ready  input  1  core accepts out_instr this cycle.
- retire  input  1  core completed one previously issued instruction.
- count  output  $clog2(DEPTH+1)  current queue occupancy.
- almost_full  output  1  count >= ALMOST_FULL_TH.
- overflow  output  1  sticky: a push was attempted while full.
- underflow  output  1  sticky: retire was asserted with zero in flight.

## Operation
- Storage is a circular buffer addressed by wr_ptr and rd_ptr, each $clog2(DEPTH)+1 bits wide; the extra MSB is the wrap bit.
  - empty: pointers are equal.
  - full: index bits are equal and wrap bits differ.
- Push occurs when in_valid && in_ready, with in_ready = !full.
  - A push is decided on the registered full flag only. A pop in the same cycle does not free a slot for that cycle's push.
- Issue occurs when out_valid && out_ready, with out_valid = !empty && (inflight < MAX_INFLIGHT).
  - out_instr is the word at rd_ptr (first-word fall-through).
  - When out_valid = 0, out_instr still shows the head word, or 0 when the queue is empty.
- count update: +1 on push only, −1 on issue only, unchanged on both or neither.
- inflight counter ($clog2(MAX_INFLIGHT+1) bits):
  - +1 on issue, −1 on retire, unchanged when both occur in the same cycle.
  - retire with inflight = 0 and no issue in that cycle: counter holds at 0 and underflow sets.
- A push while full (in_valid && full) drops the word, leaves state unchanged, and sets overflow.
- overflow and underflow clear only on reset.
- Instruction bits are never inspected or modified; routing decisions belong to the arbiter.

## Timing
- Reset values:
  - wr_ptr, rd_ptr, count, inflight = 0.
  - in_ready = 1, out_valid = 0, out_instr = 0, almost_full = 0, overflow = 0, underflow = 0.
- Latency from push to out_valid: 1 cycle. A word pushed at edge N is visible after edge N.
- Throughput: one push and one issue per cycle, sustained, while not full and inflight < MAX_INFLIGHT.
- Wrap-around: pointers increment modulo 2·DEPTH; index = low bits. No bubble at the wrap.
- A retire in cycle N raises out_valid in cycle N+1 when inflight was at MAX_INFLIGHT; there is no same-cycle credit.
- Reset asserted mid-operation discards all entries and in-flight credit immediately, asynchronously. The storage array itself is not cleared.
- in_ready, almost_full and count derive from registered state only, with no combinational path from in_valid or out_ready.

## Configuration
- CORE_DISPATCH_BYPASS_EN defined:
  - When the queue is empty, inflight < MAX_INFLIGHT and in_valid is high, the block presents out_valid = 1 and out_instr = in_instr in the same cycle.
  - If out_ready is also high, the word issues without being written: count is unchanged and inflight increments.
  - If out_ready is low, the word is written normally.
- Macro undefined: no combinational in-to-out path; minimum latency is 1 cycle as above.

## Structure
- Shared package cpu_pkg holds:
  - INSTR_W = 32.
  - Instruction field positions: bit 27 force-core flag, bit 26 core select, bits 23/22 src/dest flags, bits 21:11 dest address, bits 10:0 src address.
  - A dispatch_status_t struct {almost_full, overflow, underflow}.
- One sub-module: dq_storage, the DEPTH × INSTR_W register array with one write port and one asynchronous read port.
- Pointer, count and inflight logic stay in core_dispatch_queue.

## Test plan
- Reset, then push 0x0000_0001..0x0000_0003 with out_ready = 0 → count = 3, out_instr = 0x0000_0001, out_valid = 1 one cycle after the first push.
- Push 32 words with DEPTH = 32 → in_ready = 0 after the 32nd push and almost_full high from count = 28. A 33rd push with value 0xDEAD_BEEF sets overflow, and 0xDEAD_BEEF never appears on out_instr.
- Fill the queue, hold out_ready = 1, no retire → exactly 4 issues, then out_valid = 0. Assert retire for one cycle → exactly one further issue, on the following cycle.
- Simultaneous push and issue for 100 cycles across a pointer wrap → count stays constant and the output order equals the input order.
- Assert retire with inflight = 0 → underflow = 1 and inflight stays 0. Assert resetn low mid-burst → all outputs return to reset values within the same cycle.
- With CORE_DISPATCH_BYPASS_EN and an empty queue, push 0x0800_0ABC with out_ready = 1 → out_instr = 0x0800_0ABC in the same cycle, count stays 0, inflight = 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, instruction field positions
// and the dispatch status flags reported by each core's dispatch queue.
package cpu_pkg;

  localparam int INSTR_W = 32;

  // Instruction field positions, decoded by the arbiter only
  localparam int FORCE_CORE_BIT = 27;
  localparam int CORE_SEL_BIT   = 26;
  localparam int SRC_FLAG_BIT   = 23;
  localparam int DEST_FLAG_BIT  = 22;
  localparam int DEST_ADDR_HI   = 21;
  localparam int DEST_ADDR_LO   = 11;
  localparam int SRC_ADDR_HI    = 10;
  localparam int SRC_ADDR_LO    = 0;

  typedef logic [INSTR_W-1:0] instr_t;

  typedef struct packed {
    logic almost_full;
    logic overflow;
    logic underflow;
  } dispatch_status_t;

endpackage

// File: rtl/dq_storage.sv
// Dispatch queue word storage: DEPTH x INSTR_W register array, one write
// port and one asynchronous read port. Contents are never reset.
module dq_storage
  import cpu_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  instr_t        wr_data,
  input  logic [AW-1:0] rd_addr,
  output instr_t        rd_data
);

  instr_t mem [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (wr_en && (wr_addr == AW'(gi))) begin
          mem[gi] <= wr_data;
        end
      end
    end
  endgenerate

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/core_dispatch_queue.sv
// Per-core in-order instruction dispatch queue with an in-flight issue cap.
// Optional same-cycle empty-queue bypass enabled by CORE_DISPATCH_BYPASS_EN.
module core_dispatch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH          = 32,
  parameter int ALMOST_FULL_TH = DEPTH - 4,
  parameter int MAX_INFLIGHT   = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [INSTR_W-1:0]         in_instr,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       retire,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  logic [AW:0]      wr_ptr_reg, wr_ptr_next;
  logic [AW:0]      rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [IW-1:0]    inflight_reg, inflight_next;
  dispatch_status_t status_reg, status_next;

  logic   empty, full, credit_ok;
  logic   bypass, push, wr_en, pop, issue;
  instr_t head_instr;

  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                     (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign credit_ok = (inflight_reg < IW'(MAX_INFLIGHT));

`ifdef CORE_DISPATCH_BYPASS_EN
  assign bypass = empty && credit_ok && in_valid;
`else
  assign bypass = 1'b0;
`endif

  assign in_ready  = !full;
  assign out_valid = (!empty && credit_ok) || bypass;
  assign out_instr = bypass ? in_instr : (empty ? '0 : head_instr);

  // A bypassed word that issues immediately is never written
  assign issue = out_valid && out_ready;
  assign push  = in_valid && !full;
  assign wr_en = push && !(bypass && out_ready);
  assign pop   = issue && !empty;

  dq_storage #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_storage (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_reg[AW-1:0]),
    .wr_data (in_instr),
    .rd_addr (rd_ptr_reg[AW-1:0]),
    .rd_data (head_instr)
  );

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    inflight_next = inflight_reg;
    status_next   = status_reg;

    if (wr_en) wr_ptr_next = wr_ptr_reg + (AW+1)'(1);
    if (pop)   rd_ptr_next = rd_ptr_reg + (AW+1)'(1);

    case ({wr_en, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase

    // Retire with nothing in flight saturates at zero and is flagged
    case ({issue, retire})
      2'b10: inflight_next = inflight_reg + IW'(1);
      2'b01: if (inflight_reg != '0) inflight_next = inflight_reg - IW'(1);
      default: inflight_next = inflight_reg;
    endcase

    status_next.overflow    = status_reg.overflow || (in_valid && full);
    status_next.underflow   = status_reg.underflow ||
                              (retire && !issue && (inflight_reg == '0));
    status_next.almost_full = (int'(count_next) >= ALMOST_FULL_TH);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      inflight_reg <= '0;
      status_reg   <= '0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      inflight_reg <= inflight_next;
      status_reg   <= status_next;
    end
  end

  assign count       = count_reg;
  assign almost_full = status_reg.almost_full;
  assign overflow    = status_reg.overflow;
  assign underflow   = status_reg.underflow;

endmodule

// File: tb/tb_core_dispatch_queue.sv
// Scoreboard bench for core_dispatch_queue: directed stimulus pushes expected
// issue words into a queue; a negedge monitor checks every issued word.
module tb_core_dispatch_queue;
  import cpu_pkg::*;

  localparam int DEPTH        = 32;
  localparam int MAX_INFLIGHT = 4;
  localparam int TH           = DEPTH - 4;
  localparam int CW           = $clog2(DEPTH + 1);

  logic               clk = 1'b0;
  logic               resetn;
  logic [INSTR_W-1:0] in_instr = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [INSTR_W-1:0] out_instr;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic               retire = 1'b0;
  logic [CW-1:0]      count;
  logic               almost_full, overflow, underflow;

  int n_checks  = 0;
  int n_fail    = 0;
  int issue_cnt = 0;
  int s;
  logic [31:0] exp_q [$];

  core_dispatch_queue #(
    .DEPTH          (DEPTH),
    .ALMOST_FULL_TH (TH),
    .MAX_INFLIGHT   (MAX_INFLIGHT)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_instr    (in_instr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_instr   (out_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .retire      (retire),
    .count       (count),
    .almost_full (almost_full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Issue monitor: a handshake seen at negedge completes on the next posedge
  always @(negedge clk) begin
    if (resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      issue_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL issue_unexpected: got 0x%08h, required no issue", out_instr);
      end else begin
        check("issue_order", out_instr, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    retire    = 1'b0;
    in_instr  = '0;
    resetn    = 1'b0;
    #2;
    exp_q.delete();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1);
  end

  initial begin
    // Asynchronous reset at time 0, checked before any clock edge
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_almost_full", 32'(almost_full), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_underflow", 32'(underflow), 0);

    // Three pushes with the core stalled; head visible one cycle after push
    do_reset();
    check("empty_out_valid", 32'(out_valid), 0);
    in_valid = 1'b1;
    in_instr = 32'h1; exp_q.push_back(32'h1); tick();
    check("first_latency_valid", 32'(out_valid), 1);
    check("first_latency_instr", out_instr, 32'h1);
    in_instr = 32'h2; exp_q.push_back(32'h2); tick();
    in_instr = 32'h3; exp_q.push_back(32'h3); tick();
    in_valid = 1'b0;
    check("three_count", 32'(count), 3);
    check("three_head", out_instr, 32'h1);

    // Fill to DEPTH, then one dropped push while full
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_instr = 32'h100 + 32'(i);
      exp_q.push_back(in_instr);
      tick();
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_almost_full", 32'(almost_full), 32'((i + 1) >= TH));
    end
    check("full_in_ready", 32'(in_ready), 0);
    in_instr = 32'hDEAD_BEEF;
    tick();
    in_valid = 1'b0;
    check("full_overflow", 32'(overflow), 1);
    check("full_count", 32'(count), 32);

    // In-flight cap: four issues, then one more per retire
    out_ready = 1'b1;
    s = issue_cnt;
    repeat (8) tick();
    check("cap_issues", 32'(issue_cnt - s), 4);
    check("cap_out_valid", 32'(out_valid), 0);
    retire = 1'b1;
    check("retire_same_cycle_valid", 32'(out_valid), 0);
    tick();
    retire = 1'b0;
    check("retire_next_cycle_valid", 32'(out_valid), 1);
    repeat (4) tick();
    check("retire_issues", 32'(issue_cnt - s), 5);
    check("drain_count", 32'(count), 27);
    check("drain_almost_full", 32'(almost_full), 0);
    check("overflow_sticky", 32'(overflow), 1);

    // Sustained push + issue across the pointer wrap
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_instr = 32'h200 + 32'(i);
      exp_q.push_back(in_instr);
      tick();
    end
    s = issue_cnt;
    for (int i = 0; i < 100; i++) begin
      in_valid  = 1'b1;
      in_instr  = 32'h3000 + 32'(i);
      exp_q.push_back(in_instr);
      out_ready = 1'b1;
      retire    = (i > 0);
      tick();
      if (i % 25 == 24) check("stream_count", 32'(count), 3);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    retire    = 1'b0;
    check("stream_issues", 32'(issue_cnt - s), 100);

    // Retire with nothing in flight: flag set, credit still intact
    do_reset();
    retire = 1'b1;
    tick();
    retire = 1'b0;
    check("underflow_set", 32'(underflow), 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_instr = 32'h400 + 32'(i);
      exp_q.push_back(in_instr);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    s = issue_cnt;
    repeat (6) tick();
    check("underflow_credit_issues", 32'(issue_cnt - s), 4);
    check("underflow_count", 32'(count), 1);

    // Asynchronous reset in the middle of a burst
    in_valid = 1'b1;
    in_instr = 32'h500;
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_in_ready", 32'(in_ready), 1);
    check("mid_rst_out_instr", out_instr, 0);
    check("mid_rst_underflow", 32'(underflow), 0);
    check("mid_rst_almost_full", 32'(almost_full), 0);
    check("mid_rst_overflow", 32'(overflow), 0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("mid_rst_out_valid", 32'(out_valid), 0);
    exp_q.delete();
    tick();
    resetn = 1'b1;
    tick();

`ifdef CORE_DISPATCH_BYPASS_EN
    // Empty-queue bypass: same-cycle issue, nothing stored
    do_reset();
    in_valid  = 1'b1;
    in_instr  = 32'h0800_0ABC;
    out_ready = 1'b1;
    exp_q.push_back(in_instr);
    #1;
    check("bypass_valid", 32'(out_valid), 1);
    check("bypass_instr", out_instr, 32'h0800_0ABC);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bypass_count", 32'(count), 0);
    check("bypass_inflight", 32'(dut.inflight_reg), 1);
`endif

    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
